// File: rtl/year_counter_13bit_if.sv
// Year load channel: valid/value request toward the counter, ready/err status back.
interface year_counter_13bit_if #(
   parameter int unsigned YEAR_W = 14
);
   logic              load_valid;
   logic [YEAR_W-1:0] load_value;
   logic              load_ready;
   logic              load_err;

   modport master (output load_valid, output load_value, input load_ready, input load_err);
   modport slave  (input load_valid, input load_value, output load_ready, output load_err);
endinterface

// File: rtl/year_counter_13bit.sv
// Year register (0..MAX_YEAR) kept alongside century/year-in-century for leap detection.
// Optional feature macro: YEAR_CENTURY_TICK_EN enables the century_tick pulse on tick-driven rollovers.
module year_counter_13bit #(
   parameter  int unsigned RESET_YEAR = 2000,
   parameter  int unsigned MAX_YEAR   = 9999,
   // 9999 needs 14 bits, so the year width follows MAX_YEAR
   localparam int unsigned YEAR_W     = $clog2(MAX_YEAR + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              year_tick,
   input  logic              set_mode,
   input  logic              inc_btn,
   input  logic              dec_btn,
   year_counter_13bit_if.slave load,
   output logic [YEAR_W-1:0] year,
   output logic              leap_year,
   output logic              century_tick
);

   localparam int unsigned CEN_W = $clog2(MAX_YEAR / 100 + 1);
   localparam int unsigned YIC_W = 7;

   localparam logic [YEAR_W-1:0] MAX_Y   = YEAR_W'(MAX_YEAR);
   localparam logic [YEAR_W-1:0] RST_Y   = YEAR_W'(RESET_YEAR);
   localparam logic [YEAR_W-1:0] HUNDRED = YEAR_W'(100);
   localparam logic [CEN_W-1:0]  MAX_CEN = CEN_W'(MAX_YEAR / 100);
   localparam logic [CEN_W-1:0]  RST_CEN = CEN_W'(RESET_YEAR / 100);
   localparam logic [YIC_W-1:0]  MAX_YIC = YIC_W'(MAX_YEAR % 100);
   localparam logic [YIC_W-1:0]  RST_YIC = YIC_W'(RESET_YEAR % 100);
   localparam logic [YIC_W-1:0]  YIC_TOP = YIC_W'(99);
   localparam logic RST_LEAP = (((RESET_YEAR % 100) % 4 == 0) && (RESET_YEAR % 100 != 0)) ||
                               ((RESET_YEAR % 100 == 0) && ((RESET_YEAR / 100) % 4 == 0));

   typedef enum logic [1:0] {IDLE, SPLIT, COMMIT} state_t;

   state_t            state, state_n;
   logic [CEN_W-1:0]  cen, cen_n, cen_acc, cen_acc_n;
   logic [YIC_W-1:0]  yic, yic_n;
   logic [YEAR_W-1:0] year_n, rem, rem_n, val, val_n;
   logic              pending, pending_n;
   logic              err_n, ready_n, leap_n;
   logic              accept, tick_up, step_up, step_dn;

   // Next-state, load split and year stepping
   always_comb begin
      state_n   = state;
      cen_n     = cen;
      yic_n     = yic;
      year_n    = year;
      rem_n     = rem;
      val_n     = val;
      cen_acc_n = cen_acc;
      pending_n = pending;
      err_n     = 1'b0;
      accept    = 1'b0;
      tick_up   = 1'b0;
      step_up   = 1'b0;
      step_dn   = 1'b0;

      case (state)
         IDLE: begin
            pending_n = 1'b0;
            if (load.load_valid && (load.load_value <= MAX_Y)) begin
               accept    = 1'b1;
               state_n   = SPLIT;
               rem_n     = load.load_value;
               val_n     = load.load_value;
               cen_acc_n = '0;
            end else begin
               err_n = load.load_valid;
               if (set_mode) begin
                  step_up = inc_btn && !dec_btn;
                  step_dn = dec_btn && !inc_btn;
               end else begin
                  tick_up = year_tick || pending;
                  step_up = tick_up;
               end
            end
         end
         SPLIT: begin
            if (year_tick) pending_n = 1'b1;
            if (rem >= HUNDRED) begin
               rem_n     = rem - HUNDRED;
               cen_acc_n = cen_acc + 1'b1;
            end else begin
               state_n = COMMIT;
            end
         end
         COMMIT: begin
            if (year_tick) pending_n = 1'b1;
            year_n  = val;
            cen_n   = cen_acc;
            yic_n   = YIC_W'(rem);
            state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase

      if (step_up) begin
         if (year == MAX_Y) begin
            year_n = '0;
            cen_n  = '0;
            yic_n  = '0;
         end else begin
            year_n = year + 1'b1;
            if (yic == YIC_TOP) begin
               yic_n = '0;
               cen_n = cen + 1'b1;
            end else begin
               yic_n = yic + 1'b1;
            end
         end
      end else if (step_dn) begin
         if (year == '0) begin
            year_n = MAX_Y;
            cen_n  = MAX_CEN;
            yic_n  = MAX_YIC;
         end else begin
            year_n = year - 1'b1;
            if (yic == '0) begin
               yic_n = YIC_TOP;
               cen_n = cen - 1'b1;
            end else begin
               yic_n = yic - 1'b1;
            end
         end
      end

      leap_n  = ((yic_n[1:0] == 2'b00) && (yic_n != '0)) ||
                ((yic_n == '0) && (cen_n[1:0] == 2'b00));
      ready_n = (state_n == IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state           <= IDLE;
         year            <= RST_Y;
         cen             <= RST_CEN;
         yic             <= RST_YIC;
         leap_year       <= RST_LEAP;
         rem             <= '0;
         val             <= '0;
         cen_acc         <= '0;
         pending         <= 1'b0;
         load.load_ready <= 1'b1;
         load.load_err   <= 1'b0;
      end else begin
         state           <= state_n;
         year            <= year_n;
         cen             <= cen_n;
         yic             <= yic_n;
         leap_year       <= leap_n;
         rem             <= rem_n;
         val             <= val_n;
         cen_acc         <= cen_acc_n;
         pending         <= pending_n;
         load.load_ready <= ready_n;
         load.load_err   <= err_n;
      end
   end

`ifdef YEAR_CENTURY_TICK_EN
   // Only calendar ticks announce a new century; manual steps and loads stay silent
   logic century_n;
   assign century_n = tick_up && (yic_n == '0);

   always_ff @(posedge clk) begin
      if (rst) century_tick <= 1'b0;
      else     century_tick <= century_n;
   end
`else
   assign century_tick = 1'b0;
`endif

endmodule

// File: tb/tb_year_counter_13bit.sv
// Scoreboarded bench for year_counter_13bit: stimulus queues cycle-stamped expectations, monitor checks them.
module tb_year_counter_13bit;

   localparam int unsigned W = 14;
`ifdef YEAR_CENTURY_TICK_EN
   localparam logic CEN = 1'b1;
`else
   localparam logic CEN = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst;
   logic         year_tick;
   logic         set_mode;
   logic         inc_btn;
   logic         dec_btn;
   logic [W-1:0] year;
   logic         leap_year;
   logic         century_tick;

   year_counter_13bit_if #(.YEAR_W(W)) ld ();

   year_counter_13bit dut (
      .clk          (clk),
      .rst          (rst),
      .year_tick    (year_tick),
      .set_mode     (set_mode),
      .inc_btn      (inc_btn),
      .dec_btn      (dec_btn),
      .load         (ld),
      .year         (year),
      .leap_year    (leap_year),
      .century_tick (century_tick)
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int unsigned cyc;
      string       name;
      logic [W-1:0] y;
      logic        l;
      logic        r;
      logic        e;
      logic        c;
   } exp_t;

   exp_t sb[$];
   exp_t m;
   int   n_cmp = 0;
   int   n_bad = 0;

   // Monitor: compare every expectation that falls due at this sample point
   always @(negedge clk) begin
      while (sb.size() != 0 && sb[0].cyc <= cyc) begin
         m = sb.pop_front();
         n_cmp++;
         if (m.cyc != cyc || year !== m.y || leap_year !== m.l || ld.load_ready !== m.r ||
             ld.load_err !== m.e || century_tick !== m.c) begin
            n_bad++;
            $display("FAIL %s cyc=%0d: got year=%0d leap=%0b ready=%0b err=%0b cen=%0b, want year=%0d leap=%0b ready=%0b err=%0b cen=%0b (due cyc %0d)",
                     m.name, cyc, year, leap_year, ld.load_ready, ld.load_err, century_tick,
                     m.y, m.l, m.r, m.e, m.c, m.cyc);
         end
      end
   end

   task automatic expect_at(input int unsigned k, input string name, input logic [W-1:0] y,
                            input logic l, input logic r, input logic e, input logic c);
      exp_t x;
      x.cyc  = cyc + k;
      x.name = name;
      x.y    = y;
      x.l    = l;
      x.r    = r;
      x.e    = e;
      x.c    = c;
      sb.push_back(x);
   endtask

   task automatic pulse(input string name, input logic t, input logic i, input logic d,
                        input logic s, input logic [W-1:0] y, input logic l, input logic c);
      set_mode  = s;
      year_tick = t;
      inc_btn   = i;
      dec_btn   = d;
      expect_at(1, name, y, l, 1'b1, 1'b0, c);
      @(negedge clk);
      year_tick = 1'b0;
      inc_btn   = 1'b0;
      dec_btn   = 1'b0;
   endtask

   // Load v (quotient q = v/100); optional year_tick k cycles into the split
   task automatic do_load(input logic [W-1:0] v, input int q, input logic [W-1:0] old_y,
                          input logic old_l, input logic new_l, input int tick_k);
      expect_at(1, "load_busy", old_y, old_l, 1'b0, 1'b0, 1'b0);
      expect_at(q + 2, "load_last_busy", old_y, old_l, 1'b0, 1'b0, 1'b0);
      expect_at(q + 3, "load_commit", v, new_l, 1'b1, 1'b0, 1'b0);
      ld.load_valid = 1'b1;
      ld.load_value = v;
      for (int k = 1; k <= q + 2; k++) begin
         @(negedge clk);
         ld.load_valid = 1'b0;
         year_tick     = (k == tick_k);
      end
      year_tick = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, %0d expectations pending", sb.size());
      $fatal(1);
   end

   initial begin
      rst           = 1'b1;
      year_tick     = 1'b0;
      set_mode      = 1'b0;
      inc_btn       = 1'b0;
      dec_btn       = 1'b0;
      ld.load_valid = 1'b0;
      ld.load_value = '0;
      repeat (3) @(negedge clk);
      expect_at(1, "reset_hold", 14'd2000, 1'b1, 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      expect_at(1, "reset_idle", 14'd2000, 1'b1, 1'b1, 1'b0, 1'b0);
      @(negedge clk);

      do_load(14'd1999, 19, 14'd2000, 1'b1, 1'b0, 0);
      pulse("tick_to_2000", 1'b1, 1'b0, 1'b0, 1'b0, 14'd2000, 1'b1, CEN);

      do_load(14'd9999, 99, 14'd2000, 1'b1, 1'b0, 0);
      pulse("tick_wrap_0", 1'b1, 1'b0, 1'b0, 1'b0, 14'd0, 1'b1, CEN);
      pulse("dec_wrap_9999", 1'b0, 1'b0, 1'b1, 1'b1, 14'd9999, 1'b0, 1'b0);
      pulse("inc_wrap_0", 1'b0, 1'b1, 1'b0, 1'b1, 14'd0, 1'b1, 1'b0);
      pulse("dec_back_9999", 1'b0, 1'b0, 1'b1, 1'b1, 14'd9999, 1'b0, 1'b0);
      set_mode = 1'b0;

      ld.load_valid = 1'b1;
      ld.load_value = 14'd10000;
      expect_at(1, "err_pulse", 14'd9999, 1'b0, 1'b1, 1'b1, 1'b0);
      expect_at(2, "err_clear", 14'd9999, 1'b0, 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      ld.load_valid = 1'b0;
      @(negedge clk);

      do_load(14'd2023, 20, 14'd9999, 1'b0, 1'b0, 0);
      do_load(14'd1900, 19, 14'd2023, 1'b0, 1'b0, 5);
      expect_at(1, "pending_tick", 14'd1901, 1'b0, 1'b1, 1'b0, 1'b0);
      expect_at(2, "pending_once", 14'd1901, 1'b0, 1'b1, 1'b0, 1'b0);
      repeat (2) @(negedge clk);

      do_load(14'd2023, 20, 14'd1901, 1'b0, 1'b0, 0);
      pulse("tick_2024", 1'b1, 1'b0, 1'b0, 1'b0, 14'd2024, 1'b1, 1'b0);
      pulse("set_tick_ignored", 1'b1, 1'b0, 1'b0, 1'b1, 14'd2024, 1'b1, 1'b0);
      pulse("inc_dec_both", 1'b0, 1'b1, 1'b1, 1'b1, 14'd2024, 1'b1, 1'b0);
      pulse("set_inc", 1'b0, 1'b1, 1'b0, 1'b1, 14'd2025, 1'b0, 1'b0);
      pulse("set_dec", 1'b0, 1'b0, 1'b1, 1'b1, 14'd2024, 1'b1, 1'b0);
      pulse("inc_no_set", 1'b0, 1'b1, 1'b0, 1'b0, 14'd2024, 1'b1, 1'b0);

      ld.load_valid = 1'b1;
      ld.load_value = 14'd5000;
      expect_at(1, "split_busy", 14'd2024, 1'b1, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      ld.load_valid = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      expect_at(1, "rst_in_split", 14'd2000, 1'b1, 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      expect_at(60, "rst_abort_held", 14'd2000, 1'b1, 1'b1, 1'b0, 1'b0);
      repeat (62) @(negedge clk);
      #1;

      n_cmp++;
      if (sb.size() != 0) begin
         n_bad++;
         $display("FAIL scoreboard_drain: got %0d entries left, want 0", sb.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
